// File: rtl/gb_cpu_idu_stepper.sv
// Sequential IDU stepper: loads a base pointer and walks it through a burst of
// handshaked beats, leaving base +/- count*STEP behind for register writeback.
package gb_cpu_common_pkg;
   typedef enum logic [1:0] {
      IDU_NOP = 2'd0,
      IDU_INC = 2'd1,
      IDU_DEC = 2'd2
   } idu_opcode_t;
endpackage

module gb_cpu_idu_stepper
   import gb_cpu_common_pkg::*;
#(
   parameter int          WIDTH = 16,
   parameter int          CNT_W = 8,
   parameter int unsigned STEP  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  idu_opcode_t      opcode,
   input  logic [WIDTH-1:0] base,
   input  logic [CNT_W-1:0] count,
   input  logic             abort,
   output logic [WIDTH-1:0] addr,
   output logic             addr_valid,
   input  logic             addr_ready,
   output logic             busy,
   output logic             done
);

   localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   idu_opcode_t      op_q;
   logic [WIDTH-1:0] addr_q;
   logic [WIDTH-1:0] addr_d;
   logic [CNT_W-1:0] remaining_q;
   logic             addr_valid_q;
   logic             busy_q;
   logic             done_q;
   logic             accept;

   assign accept = addr_valid_q & addr_ready;

   // Address after one accepted beat; wraps silently modulo 2^WIDTH.
   always_comb begin
      addr_d = addr_q;
      unique case (op_q)
         IDU_INC: addr_d = addr_q + STEP_V;
         IDU_DEC: addr_d = addr_q - STEP_V;
         default: addr_d = addr_q;
      endcase
   end

   // NOTE: every register here uses <= so all updates see pre-edge values,
   // regardless of statement order inside the block.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         op_q         <= IDU_NOP;
         addr_q       <= '0;
         remaining_q  <= '0;
         addr_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  op_q        <= opcode;
                  addr_q      <= base;
                  remaining_q <= count;
                  busy_q      <= 1'b1;
                  if (count != '0) begin
                     state_q      <= S_RUN;
                     addr_valid_q <= 1'b1;
                  end else begin
                     state_q      <= S_DONE;
                     addr_valid_q <= 1'b0;
                     done_q       <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (accept) begin
                  addr_q      <= addr_d;
                  remaining_q <= remaining_q - CNT_W'(1);
               end
               // Abort beats a simultaneous final accept: beat applied, no done.
               if (abort) begin
                  state_q      <= S_IDLE;
                  addr_valid_q <= 1'b0;
                  busy_q       <= 1'b0;
               end else if (accept && remaining_q == CNT_W'(1)) begin
                  state_q      <= S_DONE;
                  addr_valid_q <= 1'b0;
                  done_q       <= 1'b1;
               end
            end
            S_DONE: begin
               state_q      <= S_IDLE;
               addr_valid_q <= 1'b0;
               busy_q       <= 1'b0;
            end
            default: begin
               state_q      <= S_IDLE;
               addr_valid_q <= 1'b0;
               busy_q       <= 1'b0;
            end
         endcase
      end
   end

   assign addr       = addr_q;
   assign addr_valid = addr_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_gb_cpu_idu_stepper.sv
// Randomized self-checking bench for gb_cpu_idu_stepper; expected beats come
// from the closed-form address base +/- k*STEP.
module tb_gb_cpu_idu_stepper;
   import gb_cpu_common_pkg::*;

   localparam int WIDTH = 16;
   localparam int CNT_W = 8;
   localparam int STEP  = 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   idu_opcode_t      opcode;
   logic [WIDTH-1:0] base;
   logic [CNT_W-1:0] count;
   logic             abort;
   logic [WIDTH-1:0] addr;
   logic             addr_valid;
   logic             addr_ready;
   logic             busy;
   logic             done;

   int checks = 0;
   int errors = 0;

   gb_cpu_idu_stepper #(.WIDTH(WIDTH), .CNT_W(CNT_W), .STEP(STEP)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .opcode     (opcode),
      .base       (base),
      .count      (count),
      .abort      (abort),
      .addr       (addr),
      .addr_valid (addr_valid),
      .addr_ready (addr_ready),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] exp_addr(input idu_opcode_t op, input logic [WIDTH-1:0] b,
                                                 input int k);
      int v;
      case (op)
         IDU_INC: v = int'(b) + k * STEP;
         IDU_DEC: v = int'(b) - k * STEP;
         default: v = int'(b);
      endcase
      return v[WIDTH-1:0];
   endfunction

   // Scribble on the burst-setup inputs so a design that re-samples them mid-burst is caught.
   task automatic scramble();
      opcode = idu_opcode_t'($urandom_range(0, 2));
      base   = WIDTH'($urandom);
      count  = CNT_W'($urandom_range(1, 255));
   endtask

   task automatic check_idle(input string tag, input logic [WIDTH-1:0] a);
      check({tag, "_addr"}, 32'(addr), 32'(a));
      check({tag, "_valid"}, 32'(addr_valid), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
   endtask

   // Called at a negedge with the DUT idle. mode: 0 ready tied 1, 1 toggle from 1, 2 random.
   // abort_at: beat index at which abort is raised (-1 none), with ready forced to abort_rdy.
   task automatic run_burst(input string tag, input idu_opcode_t op, input logic [WIDTH-1:0] b,
                            input int cnt, input int mode, input int abort_at, input bit abort_rdy);
      int  k = 0;
      int  cyc = 0;
      bit  r;
      bit  tog = 1'b1;
      bit  aborted = 1'b0;
      start = 1'b1; opcode = op; base = b; count = CNT_W'(cnt);
      @(negedge clk);
      start = 1'b0;
      scramble();
      while (k < cnt && !aborted && cyc < 2000) begin
         check({tag, "_beat_valid"}, 32'(addr_valid), 32'd1);
         check({tag, "_beat_addr"}, 32'(addr), 32'(exp_addr(op, b, k)));
         check({tag, "_beat_busy"}, 32'(busy), 32'd1);
         check({tag, "_beat_done"}, 32'(done), 32'd0);
         case (mode)
            0:       r = 1'b1;
            1:       begin r = tog; tog = ~tog; end
            default: r = 1'($urandom_range(0, 1));
         endcase
         if (k == abort_at) begin
            abort = 1'b1;
            r = abort_rdy;
            aborted = 1'b1;
         end
         addr_ready = r;
         if (mode == 2 && $urandom_range(0, 7) == 0) start = 1'b1;
         @(negedge clk);
         cyc++;
         abort = 1'b0; start = 1'b0; addr_ready = 1'b0;
         if (r) k++;
      end
      if (cyc >= 2000) begin
         check({tag, "_timeout"}, 32'(k), 32'(cnt));
         return;
      end
      if (aborted) begin
         check_idle({tag, "_abort"}, exp_addr(op, b, k));
         @(negedge clk);
         check_idle({tag, "_abort_after"}, exp_addr(op, b, k));
         return;
      end
      if (mode == 0) check({tag, "_cycles"}, 32'(cyc), 32'(cnt));
      if (mode == 1 && cnt > 0) check({tag, "_cycles"}, 32'(cyc), 32'(2 * cnt - 1));
      check({tag, "_done_pulse"}, 32'(done), 32'd1);
      check({tag, "_done_valid"}, 32'(addr_valid), 32'd0);
      check({tag, "_done_busy"}, 32'(busy), 32'd1);
      check({tag, "_done_addr"}, 32'(addr), 32'(exp_addr(op, b, cnt)));
      // Start and abort during DONE must be ignored.
      start = 1'b1; count = CNT_W'(5); abort = 1'($urandom_range(0, 1));
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check_idle({tag, "_post"}, exp_addr(op, b, cnt));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; opcode = IDU_NOP; base = '0; count = '0;
      abort = 1'b0; addr_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_idle("reset", 16'h0000);
      @(negedge clk);
      check_idle("idle_hold", 16'h0000);

      run_burst("inc_wrap", IDU_INC, 16'hFFFE, 4, 0, -1, 1'b0);
      run_burst("dec_toggle", IDU_DEC, 16'h0001, 3, 1, -1, 1'b0);
      run_burst("oam_dma", IDU_INC, 16'hFE00, 160, 0, -1, 1'b0);
      run_burst("nop", IDU_NOP, 16'hC000, 3, 0, -1, 1'b0);
      run_burst("cnt0", IDU_INC, 16'h1234, 0, 0, -1, 1'b0);
      run_burst("start_in_run", IDU_DEC, 16'h8000, 12, 2, -1, 1'b0);
      run_burst("abort_mid", IDU_INC, 16'h1000, 5, 0, 2, 1'b0);
      run_burst("abort_final", IDU_INC, 16'h2000, 5, 0, 4, 1'b1);
      run_burst("max_count", IDU_DEC, 16'h0010, 255, 2, -1, 1'b0);

      // Reset in the middle of a burst.
      start = 1'b1; opcode = IDU_INC; base = 16'h4000; count = CNT_W'(10);
      @(negedge clk);
      start = 1'b0; addr_ready = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1; addr_ready = 1'b0;
      @(negedge clk);
      check_idle("reset_mid", 16'h0000);
      reset = 1'b0;
      @(negedge clk);
      check_idle("reset_mid_after", 16'h0000);

      for (int i = 0; i < 40; i++) begin
         idu_opcode_t op;
         int          cnt;
         int          ab;
         op  = idu_opcode_t'($urandom_range(0, 2));
         cnt = $urandom_range(0, 20);
         ab  = ($urandom_range(0, 4) == 0 && cnt > 0) ? $urandom_range(0, cnt - 1) : -1;
         run_burst("rand", op, WIDTH'($urandom), cnt, 2, ab, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
